// File: rtl/bank_mapper_6509.sv
// Bank adapter for a 6502 in a 6509 socket: execution/indirect bank registers and (zp),Y cycle tracking.
// Optional TRACE_EN macro enables a registered debug snapshot on the test port.
module bank_mapper_6509 #(
  parameter int                    BANK_WIDTH  = 4,
  parameter logic [15:0]           EXEC_ADDR   = 16'h0000,
  parameter logic [15:0]           IND_ADDR    = 16'h0001,
  parameter logic [BANK_WIDTH-1:0] RESET_BANK  = '1,
  parameter bit                    IND_ALL_OPS = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r_w,
  input  logic [15:0]           address_cpu,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  input  logic                  rdy,
  input  logic                  sync,
  output logic [BANK_WIDTH-1:0] address_bank,
  output logic                  ind_active,
  output logic [7:0]            test
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPER  = 3'd1,
    PTRL  = 3'd2,
    PTRH  = 3'd3,
    DATA1 = 3'd4,
    DATA2 = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic                  opc_a0, opc_a0_nxt;
  logic [BANK_WIDTH-1:0] exec_bank, ind_bank;
  logic                  hit_exec, hit_ind, opc_match, advance;

  assign hit_exec = (address_cpu == EXEC_ADDR);
  assign hit_ind  = (address_cpu == IND_ADDR);
  // Read cycles stall while rdy is low; write cycles always complete.
  assign advance  = rdy | ~r_w;

  always_comb begin
    opc_match = 1'b0;
    if (IND_ALL_OPS)
      opc_match = (data_in[4:0] == 5'b10001);
    else
      opc_match = (data_in == 8'hB1) || (data_in == 8'h91);
  end

  always_comb begin
    state_nxt  = state;
    opc_a0_nxt = opc_a0;
    if (advance) begin
      case (state)
        IDLE: if (sync && opc_match) begin
          state_nxt  = OPER;
          opc_a0_nxt = address_cpu[0];
        end
        // A non-incrementing operand fetch means the opcode was not executed.
        OPER:  state_nxt = (address_cpu[0] != opc_a0) ? PTRL : IDLE;
        PTRL:  state_nxt = PTRH;
        PTRH:  state_nxt = DATA1;
        DATA1: state_nxt = DATA2;
        DATA2: begin
          state_nxt = IDLE;
          if (sync && opc_match) begin
            state_nxt  = OPER;
            opc_a0_nxt = address_cpu[0];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      exec_bank <= RESET_BANK;
      ind_bank  <= RESET_BANK;
    end else begin
      state <= state_nxt;
      if (!r_w && hit_exec) exec_bank <= data_in[BANK_WIDTH-1:0];
      if (!r_w && hit_ind)  ind_bank  <= data_in[BANK_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    opc_a0 <= opc_a0_nxt;
  end

  assign ind_active   = (state == DATA1) || ((state == DATA2) && !sync);
  assign address_bank = ind_active ? ind_bank : exec_bank;
  assign data_oe      = r_w & (hit_exec | hit_ind);

  always_comb begin
    data_out = 8'hFF;
    data_out[BANK_WIDTH-1:0] = hit_ind ? ind_bank : exec_bank;
  end

`ifdef TRACE_EN
  logic [7:0] trace_p0;

  always_ff @(posedge clock) begin
    if (reset) trace_p0 <= 8'h00;
    else       trace_p0 <= {state, ind_active, sync, rdy, opc_a0, r_w};
  end

  assign test = trace_p0;
`else
  assign test = 8'h00;
`endif

endmodule

// File: tb/tb_bank_mapper_6509.sv
// Scoreboard bench for bank_mapper_6509: default build plus an 8-bit, all-(zp),Y-opcode instance.
module tb_bank_mapper_6509;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r_w = 1'b1;
  logic        rdy = 1'b1;
  logic        sync = 1'b0;
  logic [15:0] address_cpu = 16'h2000;
  logic [7:0]  data_in = 8'hEA;

  logic [7:0]  data_out0, test0, data_out1, test1;
  logic        data_oe0, ind_active0, data_oe1, ind_active1;
  logic [3:0]  address_bank0;
  logic [7:0]  address_bank1;

  bank_mapper_6509 u0 (
    .clock(clock), .reset(reset), .r_w(r_w), .address_cpu(address_cpu),
    .data_in(data_in), .data_out(data_out0), .data_oe(data_oe0), .rdy(rdy),
    .sync(sync), .address_bank(address_bank0), .ind_active(ind_active0), .test(test0)
  );

  bank_mapper_6509 #(.BANK_WIDTH(8), .IND_ALL_OPS(1'b1)) u1 (
    .clock(clock), .reset(reset), .r_w(r_w), .address_cpu(address_cpu),
    .data_in(data_in), .data_out(data_out1), .data_oe(data_oe1), .rdy(rdy),
    .sync(sync), .address_bank(address_bank1), .ind_active(ind_active1), .test(test1)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [3:0] bank0;
    logic [7:0] bank1;
    logic       ind0;
    logic       ind1;
    logic       oe;
    logic [7:0] d0;
    logic [7:0] d1;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Hand-tracked register contents as seen during the current cycle.
  logic [3:0] e_exec0, e_ind0;
  logic [7:0] e_exec1, e_ind1;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc(input string name, input logic rst_i, input logic rw_i,
                     input logic [15:0] a, input logic [7:0] d, input logic rdy_i,
                     input logic sync_i, input logic ind0_i, input logic ind1_i,
                     input logic chk_i);
    exp_t e;
    @(negedge clock);
    reset = rst_i; r_w = rw_i; address_cpu = a; data_in = d; rdy = rdy_i; sync = sync_i;
    if (chk_i) begin
      e.name  = name;
      e.ind0  = ind0_i;
      e.ind1  = ind1_i;
      e.bank0 = ind0_i ? e_ind0 : e_exec0;
      e.bank1 = ind1_i ? e_ind1 : e_exec1;
      e.oe    = rw_i && ((a == 16'h0000) || (a == 16'h0001));
      e.d0    = {4'hF, (a == 16'h0001) ? e_ind0 : e_exec0};
      e.d1    = (a == 16'h0001) ? e_ind1 : e_exec1;
      sb.push_back(e);
    end
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] d,
                    input logic s, input logic i0, input logic i1);
    cyc(name, 1'b0, 1'b1, a, d, 1'b1, s, i0, i1, 1'b1);
  endtask

  task automatic wr(input string name, input logic [15:0] a, input logic [7:0] d,
                    input logic i0, input logic i1);
    cyc(name, 1'b0, 1'b0, a, d, 1'b1, 1'b0, i0, i1, 1'b1);
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, " bank0"}, {4'h0, address_bank0}, {4'h0, e.bank0});
        check({e.name, " ind0"}, {7'd0, ind_active0}, {7'd0, e.ind0});
        check({e.name, " bank1"}, address_bank1, e.bank1);
        check({e.name, " ind1"}, {7'd0, ind_active1}, {7'd0, e.ind1});
        check({e.name, " oe0"}, {7'd0, data_oe0}, {7'd0, e.oe});
        check({e.name, " oe1"}, {7'd0, data_oe1}, {7'd0, e.oe});
        if (e.oe) begin
          check({e.name, " dout0"}, data_out0, e.d0);
          check({e.name, " dout1"}, data_out1, e.d1);
        end
`ifndef TRACE_EN
        check({e.name, " test0"}, test0, 8'h00);
        check({e.name, " test1"}, test1, 8'h00);
`endif
      end
    end
  end

  initial begin
    e_exec0 = 4'hF; e_ind0 = 4'hF; e_exec1 = 8'hFF; e_ind1 = 8'hFF;
    cyc("reset", 1'b1, 1'b1, 16'h2000, 8'hEA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset values and readback
    rd("rst_fetch", 16'h2000, 8'hEA, 1'b1, 1'b0, 1'b0);
    rd("rst_rd_exec", 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("rst_rd_ind", 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0);
    wr("wr_exec", 16'h0000, 8'h03, 1'b0, 1'b0);
    e_exec0 = 4'h3; e_exec1 = 8'h03;
    wr("wr_ind", 16'h0001, 8'h0A, 1'b0, 1'b0);
    e_ind0 = 4'hA; e_ind1 = 8'h0A;
    rd("rd_exec", 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("rd_ind", 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("fetch_exec", 16'h2000, 8'hEA, 1'b1, 1'b0, 1'b0);

    // LDA (zp),Y without page cross
    rd("lda_op", 16'h2000, 8'hB1, 1'b1, 1'b0, 1'b0);
    rd("lda_zp", 16'h2001, 8'h20, 1'b0, 1'b0, 1'b0);
    rd("lda_ptrl", 16'h0020, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("lda_ptrh", 16'h0021, 8'h40, 1'b0, 1'b0, 1'b0);
    rd("lda_data", 16'h4005, 8'h55, 1'b0, 1'b1, 1'b1);
    rd("lda_next", 16'h2002, 8'hEA, 1'b1, 1'b0, 1'b0);
    rd("lda_after", 16'h2003, 8'hEA, 1'b0, 1'b0, 1'b0);

    // STA (zp),Y
    rd("sta_op", 16'h2010, 8'h91, 1'b1, 1'b0, 1'b0);
    rd("sta_zp", 16'h2011, 8'h20, 1'b0, 1'b0, 1'b0);
    rd("sta_ptrl", 16'h0020, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("sta_ptrh", 16'h0021, 8'h40, 1'b0, 1'b0, 1'b0);
    rd("sta_dummy", 16'h4005, 8'h00, 1'b0, 1'b1, 1'b1);
    wr("sta_write", 16'h4005, 8'h77, 1'b1, 1'b1);
    rd("sta_next", 16'h2012, 8'hEA, 1'b1, 1'b0, 1'b0);

    // LDA with a 3-cycle stall in PTRH, then a back-to-back LDA
    rd("stall_op", 16'h2020, 8'hB1, 1'b1, 1'b0, 1'b0);
    rd("stall_zp", 16'h2021, 8'h20, 1'b0, 1'b0, 1'b0);
    rd("stall_ptrl", 16'h0020, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("stall_hold", 1'b0, 1'b1, 16'h0021, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rd("stall_ptrh", 16'h0021, 8'h40, 1'b0, 1'b0, 1'b0);
    rd("stall_data", 16'h4005, 8'h55, 1'b0, 1'b1, 1'b1);
    rd("b2b_op", 16'h2022, 8'hB1, 1'b1, 1'b0, 1'b0);
    rd("b2b_zp", 16'h2023, 8'h30, 1'b0, 1'b0, 1'b0);
    rd("b2b_ptrl", 16'h0030, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("b2b_ptrh", 16'h0031, 8'h41, 1'b0, 1'b0, 1'b0);
    rd("b2b_data", 16'h4100, 8'h55, 1'b0, 1'b1, 1'b1);
    rd("b2b_next", 16'h2024, 8'hEA, 1'b1, 1'b0, 1'b0);

    // Abort: operand fetch with the same address[0] as the opcode
    rd("abort_op", 16'h2030, 8'hB1, 1'b1, 1'b0, 1'b0);
    rd("abort_opr", 16'h2032, 8'h20, 1'b0, 1'b0, 1'b0);
    rd("abort_c2", 16'h2033, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("abort_c3", 16'h2034, 8'h40, 1'b0, 1'b0, 1'b0);
    rd("abort_c4", 16'h2035, 8'h55, 1'b0, 1'b0, 1'b0);

    // ADC (zp),Y: only the all-opcodes instance tracks it
    rd("adc_op", 16'h2040, 8'h71, 1'b1, 1'b0, 1'b0);
    rd("adc_zp", 16'h2041, 8'h40, 1'b0, 1'b0, 1'b0);
    rd("adc_ptrl", 16'h0040, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("adc_ptrh", 16'h0041, 8'h42, 1'b0, 1'b0, 1'b0);
    rd("adc_data", 16'h4200, 8'h55, 1'b0, 1'b0, 1'b1);
    rd("adc_next", 16'h2042, 8'hEA, 1'b1, 1'b0, 1'b0);

    // Indirect-bank write during DATA1 is seen in DATA2
    rd("wind_op", 16'h2050, 8'h91, 1'b1, 1'b0, 1'b0);
    rd("wind_zp", 16'h2051, 8'h50, 1'b0, 1'b0, 1'b0);
    rd("wind_ptrl", 16'h0050, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("wind_ptrh", 16'h0051, 8'h43, 1'b0, 1'b0, 1'b0);
    wr("wind_data1", 16'h0001, 8'h05, 1'b1, 1'b1);
    e_ind0 = 4'h5; e_ind1 = 8'h05;
    wr("wind_data2", 16'h4300, 8'h77, 1'b1, 1'b1);
    rd("wind_next", 16'h2052, 8'hEA, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an instruction
    rd("rmid_op", 16'h2060, 8'hB1, 1'b1, 1'b0, 1'b0);
    rd("rmid_zp", 16'h2061, 8'h60, 1'b0, 1'b0, 1'b0);
    rd("rmid_ptrl", 16'h0060, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("rmid_ptrh", 16'h0061, 8'h44, 1'b0, 1'b0, 1'b0);
    cyc("rmid_data1", 1'b1, 1'b1, 16'h4400, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    e_exec0 = 4'hF; e_ind0 = 4'hF; e_exec1 = 8'hFF; e_ind1 = 8'hFF;
    rd("rmid_after", 16'h4401, 8'h55, 1'b0, 1'b0, 1'b0);
    rd("rmid_rd_ind", 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    #4;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bank_mapper_6509.md
Name: bank_mapper_6509

Overview:
Parametrised successor to the 6502-in-6509-socket bank adapter. It holds the execution-bank and indirect-bank registers, decodes (zp),Y instructions from the opcode stream with a cycle-tracking FSM, and drives the upper address bits. Indirect-bank selection is applied only to the data-access cycles. It sits between the 6502 bus and the system address decoder; one clock edge equals one CPU bus cycle.

Parameters:
BANK_WIDTH, 4, width of each bank register and of address_bank (1..8)
EXEC_ADDR, 16'h0000, CPU address of the execution-bank register
IND_ADDR, 16'h0001, CPU address of the indirect-bank register; must differ from EXEC_ADDR
RESET_BANK, all ones, reset value of both bank registers
IND_ALL_OPS, 0, 0 = only LDA/STA (zp),Y (0xB1/0x91); 1 = every (zp),Y opcode (0x11,0x31,0x51,0x71,0x91,0xB1,0xD1,0xF1)

Ports:
clock  in  1  CPU cycle clock; rising edge ends a bus cycle
reset  in  1  synchronous, active-high
r_w  in  1  CPU read(1)/write(0)
address_cpu  in  16  CPU address bus
data_in  in  8  CPU data bus, sampled
data_out  out  8  readback data
data_oe  out  1  drive enable for data_out
rdy  in  1  CPU RDY; low stalls read cycles
sync  in  1  CPU SYNC (opcode fetch)
address_bank  out  BANK_WIDTH  bank bits for the current cycle
ind_active  out  1  high when address_bank is sourced from the indirect register
test  out  8  debug port

Behaviour:
- Reset (sampled at clock edge): exec_bank = ind_bank = RESET_BANK; FSM = IDLE. Outputs: address_bank = RESET_BANK, ind_active = 0, data_oe = 0, test = 0.
- Register write: at an edge with !r_w and address_cpu == EXEC_ADDR (or IND_ADDR), load data_in[BANK_WIDTH-1:0]. Writes are not gated by rdy. The new value takes effect from the next cycle.
- Readback (combinational): data_oe = r_w & address hit. data_out = ones above bit BANK_WIDTH-1, with the addressed register in the low bits. Readback works from any bank. The top level gates data_oe with phi2.
- Opcode match: 0xB1/0x91, or with IND_ALL_OPS=1, data_in[4:0] == 5'b10001.
- FSM: advances only at edges where rdy=1 or r_w=0; otherwise it holds.
  - IDLE: sync & match -> OPER, latching opc_a0 = address_cpu[0].
  - OPER: if address_cpu[0] != opc_a0 -> PTRL; else -> IDLE (abort on a non-sequential operand fetch, e.g. an interrupt).
  - PTRL -> PTRH.
  - PTRH -> DATA1.
  - DATA1 -> DATA2.
  - DATA2: if sync -> IDLE (re-evaluate the opcode match in the same edge, allowing back-to-back hits). Else -> IDLE.
- Bank select: ind_active = (state == DATA1) | (state == DATA2 & !sync). address_bank = ind_active ? ind_bank : exec_bank. Both are combinational from the current state.
- LDA without page cross: 5 cycles; DATA2 coincides with the next sync, so exec bank is used. STA, or LDA with page cross: DATA1 (dummy/partial read) and DATA2 both use ind bank.
- Write to IND_ADDR during DATA1: DATA2 uses the new value.
- Reset mid-instruction: FSM -> IDLE immediately; no stale ind_active.

Optional Feature:
TRACE_EN.
- Defined: test = {state[2:0], ind_active, sync, rdy, opc_a0, r_w}, registered on clock (one-cycle latency) and cleared by reset.
- Undefined: test = 8'h00 constant, with no trace logic synthesised.

Test Plan:
- Reset: assert reset for 1 edge -> address_bank = 4'hF; read of 0x0000 and 0x0001 -> data_out = 8'hFF, data_oe = 1.
- Registers: write 0x03 to 0x0000 and 0x0A to 0x0001, then read both -> 8'hF3 and 8'hFA; address_bank = 4'h3 on an ordinary fetch.
- LDA (zp),Y without page cross: sync at 0x2000 with data 0xB1, operand at 0x2001, two pointer reads, data read, sync at 0x2002 -> ind_active = 1 only in the data cycle (address_bank = 4'hA), then 4'h3.
- STA (zp),Y: 0x91 with 6 cycles -> ind_active = 1 for the dummy-read cycle and the write cycle, then 0 at the next sync.
- Stall and abort: rdy = 0 for 3 cycles in PTRH -> state held, ind_active still exactly 2 cycles later. Operand fetch with the same address[0] as the opcode -> FSM back to IDLE, no ind cycles.
- IND_ALL_OPS: with 0, opcode 0x71 -> no ind cycles; with 1, 0x71 -> ind bank used on its data cycle. With BANK_WIDTH=8, readback = ind register value.
